// File: rtl/rs_alu.sv
// rs_alu: integer ALU reservation station with CDB snoop, age-matrix oldest-ready
// select and a registered valid/ready dispatch stage. Define RS_OCC_EN for the occupancy port.
module rs_alu #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned FUNC_W = 4,
    parameter int unsigned RD_W   = 4
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [FUNC_W-1:0] iss_func,
    input  logic [RD_W-1:0]   iss_rd,
    input  logic [TAG_W-1:0]  iss_rob,
    input  logic [DATA_W-1:0] iss_v1,
    input  logic [DATA_W-1:0] iss_v2,
    input  logic [TAG_W-1:0]  iss_q1,
    input  logic [TAG_W-1:0]  iss_q2,
    input  logic              iss_p1,
    input  logic              iss_p2,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_rs1_data,
    output logic [DATA_W-1:0] ex_rs2_data,
    output logic [FUNC_W-1:0] ex_func,
    output logic [TAG_W-1:0]  ex_rob_ind,
    output logic [RD_W-1:0]   ex_rd
`ifdef RS_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic              busy;
        logic [FUNC_W-1:0] func;
        logic [RD_W-1:0]   rd;
        logic [TAG_W-1:0]  rob;
        logic [DATA_W-1:0] v1;
        logic [TAG_W-1:0]  q1;
        logic              p1;
        logic [DATA_W-1:0] v2;
        logic [TAG_W-1:0]  q2;
        logic              p2;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    // age_q[i][j] set means entry i is older than entry j (valid among busy entries)
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];

    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] oldest;
    logic             sel_vld;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] free_idx;
    logic             iss_fire;
    logic             load;
    logic             bp1;
    logic             bp2;

    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_rs1_q, ex_rs1_d;
    logic [DATA_W-1:0] ex_rs2_q, ex_rs2_d;
    logic [FUNC_W-1:0] ex_func_q, ex_func_d;
    logic [TAG_W-1:0]  ex_rob_q, ex_rob_d;
    logic [RD_W-1:0]   ex_rd_q, ex_rd_d;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++)
            rdy[i] = ent_q[i].busy && !ent_q[i].p1 && !ent_q[i].p2;
    end

    always_comb begin
        oldest = rdy;
        for (int unsigned i = 0; i < DEPTH; i++)
            for (int unsigned j = 0; j < DEPTH; j++)
                if (i != j && rdy[j] && !age_q[i][j]) oldest[i] = 1'b0;
    end

    always_comb begin
        sel_vld = |oldest;
        sel_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            if (oldest[i]) sel_idx = IDX_W'(i);
    end

    always_comb begin
        iss_ready = 1'b0;
        free_idx  = '0;
        for (int unsigned i = DEPTH; i > 0; i--)
            if (!ent_q[i-1].busy) begin
                iss_ready = 1'b1;
                free_idx  = IDX_W'(i - 1);
            end
    end

    assign iss_fire = iss_valid && iss_ready && !flush;
    assign load     = sel_vld && (!ex_valid_q || ex_ready);
    assign bp1      = iss_p1 && cdb_valid && (cdb_tag == iss_q1);
    assign bp2      = iss_p2 && cdb_valid && (cdb_tag == iss_q2);

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            age_d[i] = age_q[i];
            if (cdb_valid && ent_q[i].busy) begin
                if (ent_q[i].p1 && ent_q[i].q1 == cdb_tag) begin
                    ent_d[i].v1 = cdb_data;
                    ent_d[i].p1 = 1'b0;
                end
                if (ent_q[i].p2 && ent_q[i].q2 == cdb_tag) begin
                    ent_d[i].v2 = cdb_data;
                    ent_d[i].p2 = 1'b0;
                end
            end
            if (load && sel_idx == IDX_W'(i)) ent_d[i].busy = 1'b0;
            if (iss_fire && free_idx == IDX_W'(i)) begin
                ent_d[i].busy = 1'b1;
                ent_d[i].func = iss_func;
                ent_d[i].rd   = iss_rd;
                ent_d[i].rob  = iss_rob;
                ent_d[i].q1   = iss_q1;
                ent_d[i].q2   = iss_q2;
                ent_d[i].v1   = bp1 ? cdb_data : iss_v1;
                ent_d[i].v2   = bp2 ? cdb_data : iss_v2;
                ent_d[i].p1   = iss_p1 && !bp1;
                ent_d[i].p2   = iss_p2 && !bp2;
                age_d[i]      = '0;
            end else if (iss_fire) begin
                age_d[i][free_idx] = 1'b1;
            end
            if (flush) ent_d[i].busy = 1'b0;
        end
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;
        ex_func_d  = ex_func_q;
        ex_rob_d   = ex_rob_q;
        ex_rd_d    = ex_rd_q;
        if (load) begin
            ex_valid_d = 1'b1;
            ex_rs1_d   = ent_q[sel_idx].v1;
            ex_rs2_d   = ent_q[sel_idx].v2;
            ex_func_d  = ent_q[sel_idx].func;
            ex_rob_d   = ent_q[sel_idx].rob;
            ex_rd_d    = ent_q[sel_idx].rd;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
        if (flush) ex_valid_d = 1'b0;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
                age_q[i] <= '0;
            end
            ex_valid_q <= 1'b0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_func_q  <= '0;
            ex_rob_q   <= '0;
            ex_rd_q    <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
                age_q[i] <= age_d[i];
            end
            ex_valid_q <= ex_valid_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
            ex_func_q  <= ex_func_d;
            ex_rob_q   <= ex_rob_d;
            ex_rd_q    <= ex_rd_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_rs1_data = ex_rs1_q;
    assign ex_rs2_data = ex_rs2_q;
    assign ex_func     = ex_func_q;
    assign ex_rob_ind  = ex_rob_q;
    assign ex_rd       = ex_rd_q;

`ifdef RS_OCC_EN
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [OCC_W-1:0] occ_q, occ_d;

    always_comb begin
        occ_d = occ_q;
        if (flush)                 occ_d = '0;
        else if (iss_fire && !load) occ_d = occ_q + OCC_W'(1);
        else if (!iss_fire && load) occ_d = occ_q - OCC_W'(1);
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) occ_q <= '0;
        else        occ_q <= occ_d;
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_rs_alu.sv
// Bench for rs_alu: directed scenarios plus random traffic against an age-ordered
// queue model of the station and its dispatch register.
`timescale 1ns/1ps
module tb_rs_alu;
    localparam int DEPTH = 4;

    logic       clk1 = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       iss_valid = 1'b0;
    logic       iss_ready;
    logic [3:0] iss_func = '0;
    logic [3:0] iss_rd = '0;
    logic [2:0] iss_rob = '0;
    logic [7:0] iss_v1 = '0;
    logic [7:0] iss_v2 = '0;
    logic [2:0] iss_q1 = '0;
    logic [2:0] iss_q2 = '0;
    logic       iss_p1 = 1'b0;
    logic       iss_p2 = 1'b0;
    logic       cdb_valid = 1'b0;
    logic [2:0] cdb_tag = '0;
    logic [7:0] cdb_data = '0;
    logic       ex_valid;
    logic       ex_ready = 1'b1;
    logic [7:0] ex_rs1_data;
    logic [7:0] ex_rs2_data;
    logic [3:0] ex_func;
    logic [2:0] ex_rob_ind;
    logic [3:0] ex_rd;
`ifdef RS_OCC_EN
    logic [2:0] occupancy;
`endif

    always #5 clk1 = ~clk1;

    rs_alu #(.DEPTH(4), .DATA_W(8), .TAG_W(3), .FUNC_W(4), .RD_W(4)) dut (
        .clk1(clk1), .rst_n(rst_n), .flush(flush),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_func(iss_func),
        .iss_rd(iss_rd), .iss_rob(iss_rob), .iss_v1(iss_v1), .iss_v2(iss_v2),
        .iss_q1(iss_q1), .iss_q2(iss_q2), .iss_p1(iss_p1), .iss_p2(iss_p2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_func(ex_func), .ex_rob_ind(ex_rob_ind),
        .ex_rd(ex_rd)
`ifdef RS_OCC_EN
        , .occupancy(occupancy)
`endif
    );

    typedef struct {
        logic [3:0] func;
        logic [3:0] rd;
        logic [2:0] rob;
        logic [7:0] v1;
        logic [7:0] v2;
        logic [2:0] q1;
        logic [2:0] q2;
        logic       p1;
        logic       p2;
    } op_t;

    op_t        rs_q[$];
    op_t        m_ex;
    logic       m_exv = 1'b0;
    logic [2:0] ex_log[$];
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Station as an age-ordered queue: oldest ready = first ready element.
    task automatic model_step();
        int   sel = -1;
        logic ld;
        logic fire;
        op_t  n;
        for (int k = 0; k < rs_q.size(); k++)
            if (sel < 0 && !rs_q[k].p1 && !rs_q[k].p2) sel = k;
        ld   = (sel >= 0) && (!m_exv || ex_ready);
        fire = iss_valid && (rs_q.size() < DEPTH) && !flush;
        if (flush) begin
            rs_q.delete();
            m_exv = 1'b0;
            return;
        end
        if (ld) begin
            m_ex  = rs_q[sel];
            m_exv = 1'b1;
        end else if (ex_ready) begin
            m_exv = 1'b0;
        end
        if (cdb_valid)
            for (int k = 0; k < rs_q.size(); k++) begin
                if (rs_q[k].p1 && rs_q[k].q1 == cdb_tag) begin rs_q[k].v1 = cdb_data; rs_q[k].p1 = 1'b0; end
                if (rs_q[k].p2 && rs_q[k].q2 == cdb_tag) begin rs_q[k].v2 = cdb_data; rs_q[k].p2 = 1'b0; end
            end
        if (ld) rs_q.delete(sel);
        if (fire) begin
            n.func = iss_func; n.rd = iss_rd; n.rob = iss_rob;
            n.v1 = iss_v1; n.v2 = iss_v2; n.q1 = iss_q1; n.q2 = iss_q2;
            n.p1 = iss_p1; n.p2 = iss_p2;
            if (iss_p1 && cdb_valid && cdb_tag == iss_q1) begin n.v1 = cdb_data; n.p1 = 1'b0; end
            if (iss_p2 && cdb_valid && cdb_tag == iss_q2) begin n.v2 = cdb_data; n.p2 = 1'b0; end
            rs_q.push_back(n);
        end
    endtask

    task automatic check_outputs();
        check("iss_ready", iss_ready, rs_q.size() < DEPTH);
        check("ex_valid", ex_valid, m_exv);
        if (m_exv) begin
            check("ex_rs1_data", ex_rs1_data, m_ex.v1);
            check("ex_rs2_data", ex_rs2_data, m_ex.v2);
            check("ex_func", ex_func, m_ex.func);
            check("ex_rob_ind", ex_rob_ind, m_ex.rob);
            check("ex_rd", ex_rd, m_ex.rd);
        end
`ifdef RS_OCC_EN
        check("occupancy", occupancy, rs_q.size());
`endif
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
        model_step();
        check_outputs();
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        iss_p1    = 1'b0;
        iss_p2    = 1'b0;
        cdb_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic drive_iss(input logic [3:0] f, input logic [3:0] rd, input logic [2:0] rob,
                             input logic [7:0] v1, input logic [7:0] v2,
                             input logic [2:0] q1, input logic [2:0] q2,
                             input logic p1, input logic p2);
        iss_valid = 1'b1;
        iss_func = f; iss_rd = rd; iss_rob = rob;
        iss_v1 = v1; iss_v2 = v2; iss_q1 = q1; iss_q2 = q2;
        iss_p1 = p1; iss_p2 = p2;
    endtask

    task automatic log_ex();
        if (ex_valid && (ex_log.size() == 0 || ex_log[$] != ex_rob_ind))
            ex_log.push_back(ex_rob_ind);
    endtask

    task automatic reset_check(input string tag);
        check({tag, ".ex_valid"}, ex_valid, 0);
        check({tag, ".iss_ready"}, iss_ready, 1);
        check({tag, ".ex_rs1"}, ex_rs1_data, 0);
        check({tag, ".ex_rs2"}, ex_rs2_data, 0);
        check({tag, ".ex_rob"}, ex_rob_ind, 0);
`ifdef RS_OCC_EN
        check({tag, ".occ"}, occupancy, 0);
`endif
    endtask

    initial begin
        logic [2:0] exp_ord[5];
        exp_ord = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd1};

        repeat (2) @(posedge clk1);
        #1;
        reset_check("reset");
        rst_n = 1'b1;

        // Both sources ready: visible at ex two edges after issue
        drive_iss(4'd0, 4'd5, 3'd2, 8'd3, 8'd4, 3'd0, 3'd0, 1'b0, 1'b0);
        step();
        idle();
        check("t1.not_yet", ex_valid, 0);
        step();
        check("t1.valid", ex_valid, 1);
        check("t1.rs1", ex_rs1_data, 8'd3);
        check("t1.rs2", ex_rs2_data, 8'd4);
        check("t1.rob", ex_rob_ind, 3'd2);
        check("t1.rd", ex_rd, 4'd5);
        repeat (2) step();

        // Pending source resolved by CDB
        drive_iss(4'd1, 4'd6, 3'd4, 8'd0, 8'd7, 3'd6, 3'd0, 1'b1, 1'b0);
        step();
        idle();
        repeat (2) step();
        cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 8'h2A;
        step();
        cdb_valid = 1'b0;
        check("t2.wait", ex_valid, 0);
        step();
        check("t2.valid", ex_valid, 1);
        check("t2.rs1", ex_rs1_data, 8'h2A);
        check("t2.rs2", ex_rs2_data, 8'd7);
        repeat (2) step();

        // Issue-cycle bypass
        drive_iss(4'd2, 4'd7, 3'd5, 8'd8, 8'd0, 3'd0, 3'd3, 1'b0, 1'b1);
        cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 8'd9;
        step();
        idle();
        step();
        check("t3.valid", ex_valid, 1);
        check("t3.rs2", ex_rs2_data, 8'd9);
        repeat (2) step();

        // Fill the station behind a stalled output, rob 1 pending
        ex_ready = 1'b0;
        for (int r = 0; r < 5; r++) begin
            drive_iss(4'(r), 4'(r + 8), 3'(r), 8'(16 + r), 8'(32 + r), 3'd7, 3'd0, r == 1, 1'b0);
            step();
            log_ex();
        end
        idle();
        check("t4.full", iss_ready, 0);
        repeat (2) begin step(); log_ex(); end
        check("t4.hold", ex_rob_ind, 3'd0);
        ex_ready = 1'b1;
        repeat (4) begin step(); log_ex(); end
        cdb_valid = 1'b1; cdb_tag = 3'd7; cdb_data = 8'h55;
        step(); log_ex();
        cdb_valid = 1'b0;
        repeat (2) begin step(); log_ex(); end
        check("t4.order_len", ex_log.size(), 5);
        for (int i = 0; i < 5 && i < ex_log.size(); i++)
            check("t4.order", ex_log[i], exp_ord[i]);

        // Flush with 3 busy, ex_valid=1, concurrent issue and CDB
        ex_ready = 1'b0;
        for (int r = 0; r < 4; r++) begin
            drive_iss(4'(r), 4'(r), 3'(r), 8'(r), 8'(r), 3'd0, 3'd0, 1'b0, 1'b0);
            step();
        end
        check("t6.pre_valid", ex_valid, 1);
        drive_iss(4'd9, 4'd9, 3'd6, 8'd1, 8'd2, 3'd0, 3'd0, 1'b0, 1'b0);
        cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 8'hEE;
        flush = 1'b1;
        step();
        idle();
        ex_ready = 1'b1;
        check("t6.ex_valid", ex_valid, 0);
        check("t6.iss_ready", iss_ready, 1);
`ifdef RS_OCC_EN
        check("t6.occ", occupancy, 0);
`endif
        step();

        // Random traffic with an asynchronous reset mid-stream
        for (int c = 0; c < 1500; c++) begin
            iss_valid = ($urandom_range(0, 9) < 6);
            iss_func  = 4'($urandom);
            iss_rd    = 4'($urandom);
            iss_rob   = 3'($urandom);
            iss_v1    = 8'($urandom);
            iss_v2    = 8'($urandom);
            iss_q1    = 3'($urandom);
            iss_q2    = 3'($urandom);
            iss_p1    = ($urandom_range(0, 9) < 3);
            iss_p2    = ($urandom_range(0, 9) < 3);
            cdb_valid = ($urandom_range(0, 1) == 1);
            cdb_tag   = 3'($urandom);
            cdb_data  = 8'($urandom);
            ex_ready  = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) < 2);
            if (c == 700) begin
                #2 rst_n = 1'b0;
                #1;
                reset_check("async_rst");
                rs_q.delete();
                m_exv = 1'b0;
                #1 rst_n = 1'b1;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
